// File: rtl/loader_pkg.sv
// Shared types and widths for the UART register bootstrap loader.
package loader_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {IDLE, COLLECT, FINISH} loader_state_t;
endpackage

// File: rtl/byte_word_packer.sv
// Shifts received bytes into a big-endian 32-bit word; strobes word_ready_o on the 4th byte.
module byte_word_packer
  import loader_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              word_ready_o,
  output logic [DATA_W-1:0] word_o
);
  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic              accept;

  always_comb begin
    accept     = en_i && rx_valid_i;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    if (clear_i) begin
      byte_cnt_d = '0;
    end else if (accept) begin
      word_d     = {word_q[23:0], rx_data_i};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  // The completed word includes the byte arriving this cycle.
  assign word_ready_o = accept && (byte_cnt_q == 2'd3);
  assign word_o       = {word_q[23:0], rx_data_i};

  always_ff @(posedge CLK) begin
    if (reset) begin
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end
endmodule

// File: rtl/uart_reg_loader.sv
// Bootstrap loader: packs UART bytes into words and writes registers FIRST_REG.. via the toggle port.
module uart_reg_loader
  import loader_pkg::*;
#(
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned NUM_REGS  = 31
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  UART_write_enable,
  output logic [REG_ADDR_W-1:0] rw,
  output logic [DATA_W-1:0]     write_data,
  output logic                  distinct,
  output logic                  busy,
  output logic                  done
);
  if (NUM_REGS < 1 || FIRST_REG + NUM_REGS - 1 > 31) begin : g_bad_params
    $error("uart_reg_loader: register range out of bounds");
  end

  localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(FIRST_REG + NUM_REGS - 1);

  loader_state_t         state_q;
  logic [REG_ADDR_W-1:0] reg_idx_q;
  logic                  wen_q, distinct_q, busy_q, done_q;
  logic [REG_ADDR_W-1:0] rw_q;
  logic [DATA_W-1:0]     wdata_q;

  logic              word_ready;
  logic [DATA_W-1:0] word;

  byte_word_packer u_packer (
    .CLK          (CLK),
    .reset        (reset),
    .clear_i      ((state_q == IDLE) && start),
    .en_i         (state_q == COLLECT),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .word_ready_o (word_ready),
    .word_o       (word)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      reg_idx_q  <= '0;
      wen_q      <= 1'b0;
      rw_q       <= '0;
      wdata_q    <= '0;
      distinct_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= COLLECT;
            busy_q    <= 1'b1;
            reg_idx_q <= FIRST_IDX;
          end
        end
        COLLECT: begin
          if (word_ready) begin
            wen_q      <= 1'b1;
            rw_q       <= reg_idx_q;
            wdata_q    <= word;
            distinct_q <= ~distinct_q;
            if (reg_idx_q == LAST_IDX) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              reg_idx_q <= reg_idx_q + 1'b1;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign UART_write_enable = wen_q;
  assign rw                = rw_q;
  assign write_data        = wdata_q;
  assign distinct          = distinct_q;
  assign busy              = busy_q;
  assign done              = done_q;
endmodule

// File: tb/tb_uart_reg_loader.sv
// Directed bench: single-word loader (NUM_REGS=1) and three-word loader (NUM_REGS=3).
module tb_uart_reg_loader;
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;

  logic        wen1, dist1, busy1, done1;
  logic [4:0]  rw1;
  logic [31:0] wd1;
  logic        wen3, dist3, busy3, done3;
  logic [4:0]  rw3;
  logic [31:0] wd3;

  int vectors = 0;
  int miscompares = 0;

  logic [4:0]  log_rw[$];
  logic [31:0] log_wd[$];
  logic        log_dist[$];
  logic        log_done[$];

  always #5 CLK = ~CLK;

  uart_reg_loader #(.FIRST_REG(1), .NUM_REGS(1)) dut1 (
    .CLK(CLK), .reset(reset), .start(start1), .rx_valid(rx_valid), .rx_data(rx_data),
    .UART_write_enable(wen1), .rw(rw1), .write_data(wd1), .distinct(dist1),
    .busy(busy1), .done(done1)
  );

  uart_reg_loader #(.FIRST_REG(1), .NUM_REGS(3)) dut3 (
    .CLK(CLK), .reset(reset), .start(start3), .rx_valid(rx_valid), .rx_data(rx_data),
    .UART_write_enable(wen3), .rw(rw3), .write_data(wd3), .distinct(dist3),
    .busy(busy3), .done(done3)
  );

  always @(negedge CLK) begin
    if (wen3 === 1'b1) begin
      log_rw.push_back(rw3);
      log_wd.push_back(wd3);
      log_dist.push_back(dist3);
      log_done.push_back(done3);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic clear_log();
    log_rw.delete(); log_wd.delete(); log_dist.delete(); log_done.delete();
  endtask

  task automatic pulse_start3();
    start3 = 1'b1;
    @(negedge CLK);
    start3 = 1'b0;
  endtask

  // Three writes to r1..r3 with toggle 0,1,0 and done only on the last.
  task automatic chk_log(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
    logic [31:0] exp_d[3];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2;
    chk({tag, "_count"}, 32'(log_rw.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_rw.size()) begin
        chk($sformatf("%s_rw%0d", tag, i), 32'(log_rw[i]), 32'(i + 1));
        chk($sformatf("%s_wd%0d", tag, i), log_wd[i], exp_d[i]);
        chk($sformatf("%s_dist%0d", tag, i), 32'(log_dist[i]), 32'(i % 2 == 0 ? 0 : 1));
        chk($sformatf("%s_done%0d", tag, i), 32'(log_done[i]), 32'(i == 2 ? 1 : 0));
      end
    end
  endtask

  initial begin
    // 1. reset defaults, rx_valid ignored in IDLE
    @(negedge CLK);
    do_reset();
    chk("rst_dist1", 32'(dist1), 32'd1);
    chk("rst_wen1", 32'(wen1), 32'd0);
    chk("rst_rw1", 32'(rw1), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_dist3", 32'(dist3), 32'd1);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    idle(2);
    chk("idle_nolog3", 32'(log_rw.size()), 32'd0);
    chk("idle_dist1", 32'(dist1), 32'd1);
    chk("idle_wen1", 32'(wen1), 32'd0);

    // 2. single word on dut1
    start1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b0;
    chk("s2_busy", 32'(busy1), 32'd1);
    send(8'hDE); send(8'hAD); send(8'hBE);
    chk("s2_nowen_early", 32'(wen1), 32'd0);
    send(8'hEF);
    chk("s2_wen", 32'(wen1), 32'd1);
    chk("s2_rw", 32'(rw1), 32'd1);
    chk("s2_wd", wd1, 32'hDEADBEEF);
    chk("s2_dist", 32'(dist1), 32'd0);
    chk("s2_done", 32'(done1), 32'd1);
    chk("s2_busy_fin", 32'(busy1), 32'd1);
    @(negedge CLK);
    chk("s2_wen_off", 32'(wen1), 32'd0);
    chk("s2_done_off", 32'(done1), 32'd0);
    chk("s2_busy_off", 32'(busy1), 32'd0);
    chk("s2_wd_hold", wd1, 32'hDEADBEEF);
    chk("s2_dist_hold", 32'(dist1), 32'd0);
    chk("s2_dut3_idle", 32'(log_rw.size()), 32'd0);

    // 3. back-to-back bytes on dut3, extra byte lands in FINISH
    clear_log();
    pulse_start3();
    for (int i = 1; i <= 12; i++) send(8'(i));
    chk("s3_fin_busy", 32'(busy3), 32'd1);
    send(8'hFF);
    chk("s3_busy_off", 32'(busy3), 32'd0);
    idle(2);
    chk_log("s3", 32'h01020304, 32'h05060708, 32'h090A0B0C);

    // 4. gapped bytes after a fresh reset
    do_reset();
    clear_log();
    pulse_start3();
    for (int i = 1; i <= 12; i++) begin
      send(8'(i));
      idle($urandom_range(0, 5));
    end
    idle(3);
    chk_log("s4", 32'h01020304, 32'h05060708, 32'h090A0B0C);
    chk("s4_busy_off", 32'(busy3), 32'd0);

    // 5/6. reset mid-word, then a stray start mid-load
    do_reset();
    clear_log();
    pulse_start3();
    send(8'hAA); send(8'hBB);
    do_reset();
    chk("s5_rst_dist", 32'(dist3), 32'd1);
    chk("s5_rst_busy", 32'(busy3), 32'd0);
    chk("s5_rst_wen", 32'(wen3), 32'd0);
    pulse_start3();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66);
    pulse_start3();
    send(8'h77); send(8'h88);
    send(8'h99); send(8'hAA); send(8'hBB); send(8'hCC);
    idle(3);
    chk_log("s56", 32'h11223344, 32'h55667788, 32'h99AABBCC);
    chk("s56_busy_off", 32'(busy3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
